mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the single external memory port between the I-cache and D-cache miss/writeback controllers.
- Sits between the two cache controllers and the memory bus.
- Grants one requester at a time, registers that requester's command, and drives the bus until the memory's ready handshake.
- Returns read data and a one-cycle ready pulse to the granted side.
- The D side has fixed priority, unless round-robin is compiled in.

Parameters:
ADDR_W, 28, memory block address width
DATA_W, 128, memory block (cache line) data width

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
i_req_read  input  1  I-cache line read request, level-held until i_ready
i_req_addr  input  ADDR_W  I-cache block address
i_rdata  output  DATA_W  read line returned to I-cache
i_ready  output  1  one-cycle completion pulse to I-cache
d_req_read  input  1  D-cache line read request, level-held until d_ready
d_req_write  input  1  D-cache writeback request, level-held until d_ready
d_req_addr  input  ADDR_W  D-cache block address
d_req_wdata  input  DATA_W  D-cache writeback line
d_rdata  output  DATA_W  read line returned to D-cache
d_ready  output  1  one-cycle completion pulse to D-cache
mem_read  output  1  memory read command
mem_write  output  1  memory write command
mem_addr  output  ADDR_W  memory block address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid with mem_ready
mem_ready  input  1  memory completion, one-cycle pulse

Behaviour:
- Reset is on rst_n, synchronous, active-low, clock clk.
- Reset values: state=IDLE; all outputs 0, including mem_read, mem_write, mem_addr, mem_wdata, i_ready, d_ready, i_rdata and d_rdata; last_grant=D.
- All outputs are driven from registers. No combinational path exists from any input to any output.

States:
- IDLE: arbitrate.
  - D request alone -> D_BUS.
  - I request alone -> I_BUS.
  - Both pending -> D_BUS (fixed priority).
  - No request -> stay in IDLE.
  - On the transition edge, latch addr (and wdata and the read/write type for D) into the bus registers and assert mem_read or mem_write.
- I_BUS / D_BUS: hold mem_read/mem_write, mem_addr and mem_wdata stable.
  - On the edge where mem_ready=1: drop mem_read/mem_write.
  - For a read, capture mem_rdata into the granted side's rdata register.
  - Pulse the granted side's ready for exactly one cycle.
  - Go to RESP.
- RESP: one cycle. Ready is high in this cycle. Always -> IDLE, with ready cleared.
- The RESP cycle gives the requester one edge to drop its level-held request, so a completed request is never re-granted.

Timing:
- Minimum latency, request to ready: request seen in IDLE at cycle 0.
  - mem_read/mem_write high from cycle 1.
  - mem_ready at cycle k>=1 -> ready high at cycle k+1.
  - Arbiter back in IDLE at cycle k+2.
- Back-to-back grants: the earliest next command asserts at cycle k+3.

Rules and boundary conditions:
- The I-side and D-side rdata registers hold their value until the next read completes for that side. Data is valid whenever ready=1.
- A request that changes address or drops while it is granted is ignored. The latched command completes unchanged.
- d_req_read and d_req_write both high is illegal. The arbiter treats it as a write.
- mem_ready seen in IDLE or RESP is ignored.
- Reset mid-transaction: return to IDLE immediately and drop every command and ready. The pending requester must re-request.
- mem_read and mem_write are never high together. At most one of i_ready and d_ready is high in any cycle.
- last_grant updates on every grant. It affects arbitration only under ARB_RR_EN.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: when both sides request in IDLE, grant the side opposite last_grant, i.e. strict alternation under contention. A lone requester is always granted immediately.
- Undefined: fixed D-over-I priority. last_grant is still maintained but unused.

Test Plan:
1. I-only read, addr=0x0000123, mem_ready at cycle 4:
   - mem_read=1 and mem_addr=0x0000123 during cycles 1-4.
   - i_ready=1 at cycle 5, with i_rdata=mem_rdata sampled at cycle 4.
   - d_ready stays 0.
2. D write, addr=0x00000A0, wdata=128'hDEAD..BEEF, mem_ready at cycle 2:
   - mem_write=1 and mem_wdata stable during cycles 1-2; mem_read stays 0.
   - d_ready pulse at cycle 3; d_rdata unchanged.
3. I read and D read asserted in the same cycle, both held, each memory access taking 3 cycles:
   - Without ARB_RR_EN: D granted first, d_ready at cycle 4. I command starts at cycle 6, i_ready at cycle 9.
   - With ARB_RR_EN after a prior D grant: I is served first instead.
4. D request changes addr from 0x10 to 0x20 mid-grant:
   - mem_addr stays 0x10 until completion.
   - After d_ready the requester drops; no second grant occurs.
5. rst_n=0 while in D_BUS:
   - Next cycle: mem_read=0, mem_write=0 and state IDLE.
   - A mem_ready pulse afterward produces no ready.
6. d_req_read and d_req_write both high: mem_write=1 and mem_read=0 for the whole transaction.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter: shares one memory port between I-cache and D-cache
// controllers; define ARB_RR_EN for round-robin arbitration. Rev 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_read,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req_read,
  input  logic              d_req_write,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, I_BUS, D_BUS, RESP} state_t;

  state_t            state, state_nxt;
  logic              last_grant, last_grant_nxt;  // 1 = D side
  logic              read_nxt, write_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic [DATA_W-1:0] i_rdata_nxt, d_rdata_nxt;
  logic              i_ready_nxt, d_ready_nxt;
  logic              d_pend, i_pend, pick_d;

  assign d_pend = d_req_read | d_req_write;
  assign i_pend = i_req_read;

`ifdef ARB_RR_EN
  // Under contention, alternate away from whoever was granted last.
  assign pick_d = d_pend & (~i_pend | ~last_grant);
`else
  assign pick_d = d_pend;
`endif

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    read_nxt       = mem_read;
    write_nxt      = mem_write;
    addr_nxt       = mem_addr;
    wdata_nxt      = mem_wdata;
    i_rdata_nxt    = i_rdata;
    d_rdata_nxt    = d_rdata;
    i_ready_nxt    = 1'b0;
    d_ready_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_d) begin
          state_nxt      = D_BUS;
          last_grant_nxt = 1'b1;
          addr_nxt       = d_req_addr;
          wdata_nxt      = d_req_wdata;
          // Read+write together is treated as a write.
          write_nxt      = d_req_write;
          read_nxt       = ~d_req_write;
        end else if (i_pend) begin
          state_nxt      = I_BUS;
          last_grant_nxt = 1'b0;
          addr_nxt       = i_req_addr;
          read_nxt       = 1'b1;
          write_nxt      = 1'b0;
        end
      end
      I_BUS: begin
        if (mem_ready) begin
          state_nxt   = RESP;
          read_nxt    = 1'b0;
          write_nxt   = 1'b0;
          i_rdata_nxt = mem_rdata;
          i_ready_nxt = 1'b1;
        end
      end
      D_BUS: begin
        if (mem_ready) begin
          state_nxt   = RESP;
          read_nxt    = 1'b0;
          write_nxt   = 1'b0;
          if (mem_read) d_rdata_nxt = mem_rdata;
          d_ready_nxt = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      mem_read   <= read_nxt;
      mem_write  <= write_nxt;
      mem_addr   <= addr_nxt;
      mem_wdata  <= wdata_nxt;
      i_rdata    <= i_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      i_ready    <= i_ready_nxt;
      d_ready    <= d_ready_nxt;
    end
  end

endmodule

`default_nettype wire
